// File: rtl/alu_md_control.sv
// alu_md_control: EX-stage ALU control decode plus an iterative
// multiply/divide unit owning the HI/LO registers.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   valid            EX-stage instruction is real (not a bubble)
//   ALUop, func      main-decoder class (3'b011 = R-type) and function field
//   src_a, src_b     rs / rt operand values
//   ALU_ctr          ALU operation code (combinational)
//   md_busy          multiply/divide in flight (registered)
//   stall            hold IF/ID/EX this cycle (combinational)
//   mf_result        HI (MFHI) or LO (MFLO) value (combinational)
//   hi, lo           architectural HI/LO registers
module alu_md_control #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [2:0]        ALUop,
  input  logic [5:0]        func,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic [3:0]        ALU_ctr,
  output logic              md_busy,
  output logic              stall,
  output logic [DATA_W-1:0] mf_result,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   acc_hi;
  logic [DATA_W-1:0]   acc_lo;
  logic [DATA_W-1:0]   opnd;
  logic                op_mul;
  logic                neg_q;
  logic                neg_r;
  logic                div_zero;

  logic                rtype;
  logic                md_op;
  logic                mfmt_op;
  logic                md_start;
  logic                op_signed;
  logic                a_neg;
  logic                b_neg;
  logic [DATA_W-1:0]   a_mag;
  logic [DATA_W-1:0]   b_mag;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     div_shift;
  logic [DATA_W:0]     div_diff;
  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   q_fix;
  logic [DATA_W-1:0]   r_fix;

  // ALU operation decode
  always_comb begin
    ALU_ctr = 4'b0000;
    case (ALUop)
      3'b000: ALU_ctr = 4'b0010;
      3'b001: ALU_ctr = 4'b0110;
      3'b010: ALU_ctr = 4'b0111;
      3'b100: ALU_ctr = 4'b0000;
      3'b101: ALU_ctr = 4'b0001;
      3'b110: ALU_ctr = 4'b1000;
      3'b011: begin
        case (func)
          6'h21: ALU_ctr = 4'b0010;
          6'h23: ALU_ctr = 4'b0110;
          6'h24: ALU_ctr = 4'b0000;
          6'h25: ALU_ctr = 4'b0001;
          6'h2A: ALU_ctr = 4'b0111;
          6'h00, 6'h04: ALU_ctr = 4'b0011;
          6'h03, 6'h07: ALU_ctr = 4'b0100;
          6'h02, 6'h06: ALU_ctr = 4'b0101;
          6'h26: ALU_ctr = 4'b1000;
          6'h27: ALU_ctr = 4'b1001;
          6'h2B: ALU_ctr = 4'b1010;
          6'h10, 6'h11, 6'h12, 6'h13,
          6'h18, 6'h19, 6'h1A, 6'h1B: ALU_ctr = 4'b1111;
          default: ALU_ctr = 4'b0000;
        endcase
      end
      default: ALU_ctr = 4'b0000;
    endcase
  end

  // MD decode and datapath
  always_comb begin
    rtype     = (ALUop == 3'b011);
    md_op     = (func[5:2] == 4'b0110);   // 0x18..0x1B
    mfmt_op   = (func[5:2] == 4'b0100);   // 0x10..0x13
    md_start  = valid & rtype & md_op & (state == S_IDLE);
    stall     = valid & rtype & (md_op | mfmt_op) & md_busy;
    mf_result = (func == 6'h10) ? hi : lo;

    op_signed = ~func[0];
    a_neg     = op_signed & src_a[DATA_W-1];
    b_neg     = op_signed & src_b[DATA_W-1];
    a_mag     = a_neg ? (~src_a + 1'b1) : src_a;
    b_mag     = b_neg ? (~src_b + 1'b1) : src_b;

    // Shift-add: add multiplicand when the current multiplier bit is set,
    // then shift {carry, acc_hi, acc_lo} right by one.
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    // Restoring step: remainder lives in acc_hi, dividend/quotient in acc_lo.
    // Top bit of the difference set means the trial subtraction borrowed.
    div_shift = {acc_hi, acc_lo[DATA_W-1]};
    div_diff  = div_shift - {1'b0, opnd};

    prod      = {acc_hi, acc_lo};
    prod_fix  = neg_q ? (~prod + 1'b1) : prod;
    q_fix     = neg_q ? (~acc_lo + 1'b1) : acc_lo;
    r_fix     = neg_r ? (~acc_hi + 1'b1) : acc_hi;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      md_busy  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      op_mul   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (md_start) begin
            md_busy  <= 1'b1;
            cnt      <= CNT_W'(DATA_W - 1);
            op_mul   <= ~func[1];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= 1'b0;
            if (!func[1]) begin
              acc_hi <= '0;
              acc_lo <= b_mag;
              opnd   <= a_mag;
              state  <= S_MUL;
            end else if (src_b == '0) begin
              // Divide by zero: results staged directly, sign fix bypassed.
              acc_hi   <= src_a;
              acc_lo   <= '1;
              div_zero <= 1'b1;
              state    <= S_FIX;
            end else begin
              acc_hi <= '0;
              acc_lo <= a_mag;
              opnd   <= b_mag;
              state  <= S_DIV;
            end
          end else if (valid && rtype && !stall) begin
            if (func == 6'h11) hi <= src_a;
            if (func == 6'h13) lo <= src_a;
          end
        end
        S_MUL: begin
          {acc_hi, acc_lo} <= {mul_sum, acc_lo[DATA_W-1:1]};
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - 1'b1;
        end
        S_DIV: begin
          if (div_diff[DATA_W]) begin
            acc_hi <= div_shift[DATA_W-1:0];
            acc_lo <= {acc_lo[DATA_W-2:0], 1'b0};
          end else begin
            acc_hi <= div_diff[DATA_W-1:0];
            acc_lo <= {acc_lo[DATA_W-2:0], 1'b1};
          end
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - 1'b1;
        end
        S_FIX: begin
          if (div_zero) begin
            hi <= acc_hi;
            lo <= acc_lo;
          end else if (op_mul) begin
            {hi, lo} <= prod_fix;
          end else begin
            hi <= r_fix;
            lo <= q_fix;
          end
          md_busy <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
